// File: rtl/dma_rd_arbiter_pkg.sv
// rtl/dma_rd_arbiter_pkg.sv - shared defaults, FSM encodings and index helpers for dma_rd_arbiter
package dma_rd_arbiter_pkg;

  localparam int DEF_NUM_REQ      = 3;
  localparam int DEF_BITS_TRANS   = 18;
  localparam int DEF_AXI_WIDTH_AD = 32;
  localparam int DEF_AXI_WIDTH_DA = 32;
  localparam int DEF_TIMEOUT_CYC  = 4096;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Requester index 'off' positions past 'base', wrapping at n.
  function automatic int rr_index(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dma_rd_arbiter_rr_pick.sv
// rtl/dma_rd_arbiter_rr_pick.sv - combinational round-robin select: first request at/after ptr
module dma_rr_pick
  import dma_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'(rr_index(int'(ptr), i, NUM_REQ));
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_oh = any ? (NUM_REQ'(1) << gnt_idx) : '0;

endmodule

// File: rtl/dma_rd_arbiter.sv
// rtl/dma_rd_arbiter.sv - round-robin sharing of one axi_dma_rd engine; watchdog under DMA_RD_ARB_TIMEOUT_EN
module dma_rd_arbiter
  import dma_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int BITS_TRANS   = DEF_BITS_TRANS,
  parameter int AXI_WIDTH_AD = DEF_AXI_WIDTH_AD,
  parameter int AXI_WIDTH_DA = DEF_AXI_WIDTH_DA,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*BITS_TRANS-1:0]   req_num_trans_i,
  input  logic [NUM_REQ*AXI_WIDTH_AD-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [AXI_WIDTH_DA-1:0]         rd_data_o,
  output logic [NUM_REQ-1:0]              rd_vld_o,
  output logic [NUM_REQ-1:0]              rd_done_o,
  output logic                            busy_o,
  output logic                            dma_start_o,
  output logic [BITS_TRANS-1:0]           dma_num_trans_o,
  output logic [AXI_WIDTH_AD-1:0]         dma_start_addr_o,
  input  logic [AXI_WIDTH_DA-1:0]         dma_data_i,
  input  logic                            dma_data_vld_i,
  input  logic                            dma_done_i,
  output logic [NUM_REQ-1:0]              err_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]              state;
  logic [NUM_REQ-1:0]      gnt;
  logic [IW-1:0]           gnt_idx;
  logic [IW-1:0]           ptr;
  logic [BITS_TRANS-1:0]   num_trans;
  logic [AXI_WIDTH_AD-1:0] start_addr;

  logic [NUM_REQ-1:0]      pick_oh;
  logic [IW-1:0]           pick_idx;
  logic                    pick_any;
  logic [BITS_TRANS-1:0]   pick_trans;
  logic [AXI_WIDTH_AD-1:0] pick_addr;

  logic                    timeout_hit;
  logic                    locked;

  dma_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req     (req_i),
    .ptr     (ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign pick_trans = req_num_trans_i[pick_idx*BITS_TRANS +: BITS_TRANS];
  assign pick_addr  = req_addr_i[pick_idx*AXI_WIDTH_AD +: AXI_WIDTH_AD];

  // A zero-length job skips the engine entirely and completes through DONE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      gnt_idx    <= '0;
      ptr        <= '0;
      num_trans  <= '0;
      start_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any && !locked) begin
            gnt        <= pick_oh;
            gnt_idx    <= pick_idx;
            num_trans  <= pick_trans;
            start_addr <= pick_addr;
            state      <= (pick_trans == '0) ? ST_DONE : ST_START;
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          if (dma_done_i || timeout_hit) state <= ST_DONE;
        end
        default: begin
          gnt   <= '0;
          ptr   <= IW'(wrap_inc(int'(gnt_idx), NUM_REQ));
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_o            = gnt;
  assign busy_o           = (state != ST_IDLE);
  assign dma_start_o      = (state == ST_START);
  assign dma_num_trans_o  = num_trans;
  assign dma_start_addr_o = start_addr;
  assign rd_data_o        = dma_data_i;
  assign rd_vld_o         = (state == ST_WAIT && dma_data_vld_i) ? gnt : '0;
  assign rd_done_o        = (state == ST_DONE) ? gnt : '0;

`ifdef DMA_RD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0]      idle_cnt;
  logic [NUM_REQ-1:0] err;

  // Counts consecutive beatless WAIT cycles; a done in the same cycle wins over the watchdog.
  assign timeout_hit = (state == ST_WAIT) && !dma_done_i && !dma_data_vld_i &&
                       (idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idle_cnt <= '0;
      err      <= '0;
      locked   <= 1'b0;
    end else begin
      if (state != ST_WAIT || dma_data_vld_i) idle_cnt <= '0;
      else                                    idle_cnt <= idle_cnt + 1'b1;
      if (timeout_hit) begin
        err    <= err | gnt;
        locked <= 1'b1;
      end
    end
  end

  assign err_o = err;
`else
  assign timeout_hit = 1'b0;
  assign locked      = 1'b0;
  assign err_o       = '0;
`endif

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// tb/tb_dma_rd_arbiter.sv - randomized self-checking bench with a DMA responder and arbitration model
module tb_dma_rd_arbiter;

  localparam int NR = 3;
  localparam int BT = 18;
  localparam int AD = 32;
  localparam int DA = 32;
  localparam int TB_TIMEOUT = 32;

  logic           clk = 1'b0;
  logic           rstn;
  logic [NR-1:0]  req;
  logic [NR*BT-1:0] req_num_trans;
  logic [NR*AD-1:0] req_addr;
  logic [NR-1:0]  gnt_o, rd_vld_o, rd_done_o, err_o;
  logic [DA-1:0]  rd_data_o, dma_data_i;
  logic           busy_o, dma_start_o, dma_data_vld_i, dma_done_i;
  logic [BT-1:0]  dma_num_trans_o;
  logic [AD-1:0]  dma_start_addr_o;

  always #5 clk = ~clk;

  dma_rd_arbiter #(
    .NUM_REQ(NR), .BITS_TRANS(BT), .AXI_WIDTH_AD(AD), .AXI_WIDTH_DA(DA), .TIMEOUT_CYC(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .req_i(req), .req_num_trans_i(req_num_trans), .req_addr_i(req_addr),
    .gnt_o(gnt_o), .rd_data_o(rd_data_o), .rd_vld_o(rd_vld_o), .rd_done_o(rd_done_o),
    .busy_o(busy_o), .dma_start_o(dma_start_o), .dma_num_trans_o(dma_num_trans_o),
    .dma_start_addr_o(dma_start_addr_o), .dma_data_i(dma_data_i), .dma_data_vld_i(dma_data_vld_i),
    .dma_done_i(dma_done_i), .err_o(err_o)
  );

  int n_chk = 0;
  int n_fail = 0;
  int model_ptr;
  int exp_nt [NR];
  logic [AD-1:0] exp_ad [NR];

  int r_starts, r_start_cyc, r_vld_cnt, r_bad, r_done_cyc, r_err_cyc, r_last_beat;
  logic [NR-1:0] r_gnt, r_done;
  logic [BT-1:0] r_nt;
  logic [AD-1:0] r_ad;

  // Next winner: first pending requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [NR-1:0] r, input int p);
    logic [NR-1:0] sh;
    for (int k = 0; k < NR; k++) begin
      sh = r >> ((p + k) % NR);
      if (sh[0]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input int nt, input logic [AD-1:0] ad);
    req_num_trans[i*BT +: BT] = BT'(nt);
    req_addr[i*AD +: AD] = ad;
    exp_nt[i] = nt;
    exp_ad[i] = ad;
    req = req | (NR'(1) << i);
  endtask

  task automatic drop_req(input int i);
    req = req & ~(NR'(1) << i);
  endtask

  task automatic reset_dut();
    rstn = 1'b0; req = '0; dma_data_vld_i = 1'b0; dma_done_i = 1'b0; dma_data_i = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    model_ptr = 0;
  endtask

  // Plays the DMA engine for one job and records what the arbiter did, until rd_done_o or budget.
  task automatic run_dma(input int exp_idx, input int stall_after, input int budget);
    int remaining, sent;
    bit active;
    logic [NR-1:0] exp_oh;
    exp_oh = NR'(1) << exp_idx;
    r_starts = 0; r_start_cyc = -1; r_vld_cnt = 0; r_bad = 0; r_done_cyc = -1;
    r_err_cyc = -1; r_last_beat = -1; r_gnt = '0; r_done = '0; r_nt = '1; r_ad = '1;
    remaining = 0; sent = 0; active = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (gnt_o !== '0) begin
        if (r_gnt === '0) r_gnt = gnt_o;
        if (gnt_o !== exp_oh) r_bad++;
      end
      if (dma_start_o) begin
        r_starts++;
        if (r_start_cyc < 0) r_start_cyc = c;
        r_nt = dma_num_trans_o; r_ad = dma_start_addr_o;
        remaining = int'(dma_num_trans_o); active = 1'b1;
      end
      if (rd_vld_o !== (dma_data_vld_i ? exp_oh : '0)) r_bad++;
      if (dma_data_vld_i) begin
        r_last_beat = c;
        if (rd_vld_o === exp_oh) r_vld_cnt++;
        if (rd_data_o !== dma_data_i) r_bad++;
      end
      if (err_o !== '0 && r_err_cyc < 0) r_err_cyc = c;
      if (rd_done_o !== '0) begin
        r_done = rd_done_o; r_done_cyc = c;
        break;
      end
      @(posedge clk);
      #1;
      dma_data_vld_i = 1'b0; dma_done_i = 1'b0;
      if (active) begin
        if (remaining > 0 && !(stall_after >= 0 && sent >= stall_after)) begin
          if ($urandom_range(3, 0) != 0) begin
            dma_data_vld_i = 1'b1; dma_data_i = $urandom;
            remaining--; sent++;
            if (remaining == 0 && $urandom_range(1, 0) == 1) begin
              dma_done_i = 1'b1; active = 1'b0;
            end
          end
        end else if (remaining == 0) begin
          dma_done_i = 1'b1; active = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    n_chk++;
    if ({gnt_o, rd_vld_o, rd_done_o, err_o, busy_o, dma_start_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%0h want=0", {gnt_o, rd_vld_o, rd_done_o, err_o, busy_o, dma_start_o});
    end
    n_chk++;
    if ({dma_num_trans_o, dma_start_addr_o} !== '0) begin
      n_fail++; $display("FAIL reset_job got=%0h want=0", {dma_num_trans_o, dma_start_addr_o});
    end
  endtask

  task automatic test_single();
    reset_dut();
    set_req(0, 64, 32'h0);
    run_dma(0, -1, 400);
    drop_req(0);
    n_chk++; if (r_gnt !== 3'b001) begin n_fail++; $display("FAIL single_gnt got=%b want=001", r_gnt); end
    n_chk++; if (r_starts !== 1) begin n_fail++; $display("FAIL single_starts got=%0d want=1", r_starts); end
    n_chk++; if (r_start_cyc !== 1) begin n_fail++; $display("FAIL single_start_lat got=%0d want=1", r_start_cyc); end
    n_chk++; if (r_nt !== 18'd64) begin n_fail++; $display("FAIL single_nt got=%0d want=64", r_nt); end
    n_chk++; if (r_ad !== 32'h0) begin n_fail++; $display("FAIL single_addr got=%0h want=0", r_ad); end
    n_chk++; if (r_vld_cnt !== 64) begin n_fail++; $display("FAIL single_beats got=%0d want=64", r_vld_cnt); end
    n_chk++; if (r_bad !== 0) begin n_fail++; $display("FAIL single_steer got=%0d want=0", r_bad); end
    n_chk++; if (r_done !== 3'b001) begin n_fail++; $display("FAIL single_done got=%b want=001", r_done); end
    @(negedge clk);
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%b want=0", busy_o); end
  endtask

  task automatic test_back_to_back();
    int e;
    reset_dut();
    for (int i = 0; i < NR; i++) set_req(i, 16, 32'h1000 * (i + 1));
    for (int k = 0; k < NR; k++) begin
      e = model_pick(req, model_ptr);
      run_dma(e, -1, 200);
      drop_req(e);
      model_ptr = (e + 1) % NR;
      n_chk++; if (r_gnt !== (NR'(1) << k)) begin n_fail++; $display("FAIL b2b_order[%0d] got=%b want=%b", k, r_gnt, NR'(1) << k); end
      n_chk++; if (r_done !== (NR'(1) << e)) begin n_fail++; $display("FAIL b2b_done[%0d] got=%b want=%b", k, r_done, NR'(1) << e); end
      n_chk++; if (r_vld_cnt !== 16 || r_bad !== 0) begin n_fail++; $display("FAIL b2b_beats[%0d] got=%0d/%0d want=16/0", k, r_vld_cnt, r_bad); end
      n_chk++; if (r_ad !== exp_ad[e]) begin n_fail++; $display("FAIL b2b_addr[%0d] got=%0h want=%0h", k, r_ad, exp_ad[e]); end
      n_chk++; if (r_start_cyc !== 1) begin n_fail++; $display("FAIL b2b_gap[%0d] got=%0d want=1", k, r_start_cyc); end
    end
  endtask

  task automatic test_rr_wrap();
    int e;
    reset_dut();
    set_req(1, 4, 32'hA0);
    run_dma(1, -1, 100);
    drop_req(1);
    model_ptr = 2;
    n_chk++; if (r_done !== 3'b010) begin n_fail++; $display("FAIL wrap_first got=%b want=010", r_done); end
    set_req(0, 4, 32'hB0);
    set_req(1, 4, 32'hC0);
    e = model_pick(req, model_ptr);
    run_dma(e, -1, 100);
    drop_req(e);
    model_ptr = (e + 1) % NR;
    n_chk++; if (r_gnt !== 3'b001) begin n_fail++; $display("FAIL wrap_winner got=%b want=001", r_gnt); end
    n_chk++; if (r_ad !== 32'hB0) begin n_fail++; $display("FAIL wrap_addr got=%0h want=b0", r_ad); end
    run_dma(1, -1, 100);
    drop_req(1);
    n_chk++; if (r_done !== 3'b010) begin n_fail++; $display("FAIL wrap_second got=%b want=010", r_done); end
  endtask

  task automatic test_zero_len();
    reset_dut();
    set_req(2, 0, 32'hDEAD0000);
    run_dma(2, -1, 20);
    drop_req(2);
    n_chk++; if (r_starts !== 0) begin n_fail++; $display("FAIL zero_start got=%0d want=0", r_starts); end
    n_chk++; if (r_done !== 3'b100) begin n_fail++; $display("FAIL zero_done got=%b want=100", r_done); end
    n_chk++; if (r_done_cyc !== 1) begin n_fail++; $display("FAIL zero_lat got=%0d want=1", r_done_cyc); end
  endtask

  task automatic test_reset_mid_job();
    bit seen;
    reset_dut();
    set_req(0, 32, 32'h4000);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (dma_start_o) seen = 1'b1;
    end
    n_chk++; if (seen !== 1'b1) begin n_fail++; $display("FAIL midrst_start got=%b want=1", seen); end
    for (int b = 1; b <= 10; b++) begin
      @(posedge clk);
      #1 dma_data_vld_i = 1'b1; dma_data_i = $urandom;
      if (b == 10) rstn = 1'b0;
    end
    @(posedge clk);
    #1 dma_data_vld_i = 1'b0;
    n_chk++;
    if ({gnt_o, busy_o, rd_vld_o, rd_done_o} !== '0) begin
      n_fail++; $display("FAIL midrst_clear got=%0h want=0", {gnt_o, busy_o, rd_vld_o, rd_done_o});
    end
    rstn = 1'b1; req = '0; model_ptr = 0;
    set_req(0, 8, 32'h5000);
    run_dma(0, -1, 100);
    drop_req(0);
    n_chk++; if (r_done !== 3'b001 || r_starts !== 1) begin n_fail++; $display("FAIL midrst_restart got=%b/%0d want=001/1", r_done, r_starts); end
    n_chk++; if (r_vld_cnt !== 8 || r_bad !== 0) begin n_fail++; $display("FAIL midrst_beats got=%0d/%0d want=8/0", r_vld_cnt, r_bad); end
  endtask

  task automatic test_random();
    int e;
    logic [NR-1:0] m;
    reset_dut();
    for (int round = 0; round < 20; round++) begin
      m = NR'($urandom);
      for (int i = 0; i < NR; i++)
        if (m[i] && !req[i]) set_req(i, $urandom_range(24, 0), $urandom);
      if (req == '0) set_req(0, $urandom_range(24, 0), $urandom);
      e = model_pick(req, model_ptr);
      run_dma(e, -1, 300);
      drop_req(e);
      model_ptr = (e + 1) % NR;
      n_chk++; if (r_done !== (NR'(1) << e)) begin n_fail++; $display("FAIL rand_done[%0d] got=%b want=%b", round, r_done, NR'(1) << e); end
      n_chk++; if (r_vld_cnt !== exp_nt[e] || r_bad !== 0) begin n_fail++; $display("FAIL rand_beats[%0d] got=%0d/%0d want=%0d/0", round, r_vld_cnt, r_bad, exp_nt[e]); end
      n_chk++; if (r_starts !== ((exp_nt[e] == 0) ? 0 : 1)) begin n_fail++; $display("FAIL rand_starts[%0d] got=%0d nt=%0d", round, r_starts, exp_nt[e]); end
      if (exp_nt[e] != 0) begin
        n_chk++; if (r_ad !== exp_ad[e]) begin n_fail++; $display("FAIL rand_addr[%0d] got=%0h want=%0h", round, r_ad, exp_ad[e]); end
      end
    end
  endtask

`ifdef DMA_RD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int grants;
    reset_dut();
    set_req(1, 20, 32'h7000);
    run_dma(1, 5, 200);
    n_chk++; if (r_vld_cnt !== 5) begin n_fail++; $display("FAIL to_beats got=%0d want=5", r_vld_cnt); end
    n_chk++; if (r_done !== 3'b010) begin n_fail++; $display("FAIL to_done got=%b want=010", r_done); end
    n_chk++; if (r_err_cyc - r_last_beat !== TB_TIMEOUT + 1) begin n_fail++; $display("FAIL to_delay got=%0d want=%0d", r_err_cyc - r_last_beat, TB_TIMEOUT + 1); end
    n_chk++; if (err_o !== 3'b010) begin n_fail++; $display("FAIL to_err got=%b want=010", err_o); end
    for (int i = 0; i < NR; i++) set_req(i, 4, 32'h100 * i);
    grants = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt_o !== '0 || busy_o !== 1'b0) grants++;
    end
    n_chk++; if (grants !== 0) begin n_fail++; $display("FAIL to_locked got=%0d want=0", grants); end
    n_chk++; if (err_o !== 3'b010) begin n_fail++; $display("FAIL to_sticky got=%b want=010", err_o); end
  endtask
`endif

  initial begin
    rstn = 1'b0; req = '0; req_num_trans = '0; req_addr = '0;
    dma_data_i = '0; dma_data_vld_i = 1'b0; dma_done_i = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_wrap();
    test_zero_len();
    test_reset_mid_job();
    test_random();
`ifdef DMA_RD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
